eth_rx_frame_checker: RTL
=========================

Name: eth_rx_frame_checker

Overview:
- Sits directly downstream of packet_receiver, the RMII receive path that turns dibits into post-SFD bytes.
- Consumes that byte stream, which includes the 4-byte FCS, and computes CRC-32 on the fly.
- Enforces length limits and strips the FCS before forwarding the payload bytes.
- Reports a per-frame status and keeps good/bad frame counters, which top uses to drive the LED and for debug.

Parameters:
- MIN_LEN, 64: minimum frame length in bytes, FCS included; shorter frames are flagged runt.
- MAX_LEN, 1518: maximum frame length in bytes, FCS included; longer frames are flagged oversize.
- CNT_W, 16: width of the good/bad frame counters.

Ports:
- clk  in  1  50 MHz RMII reference clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  received byte, LSB first on the wire.
- in_valid  in  1  in_data is valid this cycle; no backpressure exists.
- in_sof  in  1  qualifies the first byte after SFD; only meaningful with in_valid.
- in_eof  in  1  qualifies the last byte of the frame (last FCS byte); only meaningful with in_valid.
- out_data  out  8  payload byte, FCS removed.
- out_valid  out  1  out_data is valid.
- out_sof  out  1  first payload byte.
- out_eof  out  1  last payload byte.
- out_abort  out  1  one-cycle pulse: the in-progress output frame was truncated by a new in_sof.
- frame_done  out  1  one-cycle pulse at end of every frame.
- frame_ok  out  1  valid with frame_done: CRC good and length within limits.
- frame_err  out  3  valid with frame_done: {oversize, runt, crc_bad}.
- frame_len  out  11  valid with frame_done: byte count including FCS, saturating at 2047.
- good_cnt  out  CNT_W  frames with frame_ok=1, wraps.
- bad_cnt  out  CNT_W  frames with frame_ok=0, wraps.

Behaviour:
- Reset:
  - All outputs are 0 and the counters are 0.
  - CRC register is 0xFFFFFFFF and the state is IDLE.
  - Reset mid-frame discards the frame with no frame_done and no out_abort.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, 8 bits per valid byte, processed LSB first.
  - Covers every byte of the frame, FCS included.
  - A frame is good iff the raw register equals the residue 0xDEBB20E3 after the in_eof byte.
- Delay line:
  - 4-entry byte shift register that holds back the trailing FCS.
  - On each valid byte with count ≥ 4 (bytes already held), the oldest byte is emitted one cycle later.
  - Registered outputs: latency is exactly 1 clk from the input beat that pushes the byte out.
  - out_sof accompanies the first emitted byte of the frame.
  - out_eof accompanies the byte emitted on the in_eof beat.
  - The 4 held bytes (the FCS) are never emitted.
- States:
  - IDLE:
    - in_valid&in_sof → RX: clear CRC to 0xFFFFFFFF, then fold the byte, len=1, fill slot 0.
    - in_valid without in_sof is ignored and produces no status.
  - RX:
    - Each in_valid: fold CRC, len++ (saturating), shift the delay line.
    - in_valid&in_eof → IDLE. frame_done pulses 1 cycle after that beat; frame_ok, frame_err and frame_len are held until the next frame_done.
    - in_valid&in_sof (no eof) while in RX is a restart:
      - If any byte was emitted, out_abort pulses (out_eof is not asserted).
      - The old frame reports frame_done with crc_bad=1, plus runt if its len < MIN_LEN, and bad_cnt increments.
      - The new frame starts with this byte, in the same cycle.
    - in_sof&in_eof on the same beat in IDLE: a 1-byte frame; status is runt|crc_bad with no output bytes.
- Length and error flags:
  - runt = len < MIN_LEN.
  - oversize = len > MAX_LEN.
  - Payload is still forwarded for bad frames; downstream discards on frame_ok=0.
  - Frames with len ≤ 4 emit no output bytes; out_sof and out_eof are then never asserted.
- Counters increment in the frame_done cycle and wrap modulo 2^CNT_W.
- in_valid gaps inside a frame are legal; state, CRC and delay line hold.

Test Plan:
- MIN_LEN=4: frame "123456789" (0x31..0x39) + FCS bytes 26 39 F4 CB → out emits 0x31..0x39, out_sof on 0x31, out_eof on 0x39; frame_ok=1, frame_err=0, frame_len=13, good_cnt=1.
- Same frame with FCS byte 0xCB flipped to 0xCA → identical out bytes; frame_ok=0, frame_err=3'b001, bad_cnt=1.
- Default params: 64-byte frame, 60×0x00 + correct FCS, fed back-to-back with a 1000-cycle idle gap and random in_valid gaps → 60 out bytes each with 1-cycle latency; good_cnt=2.
- Default params: 20-byte frame with valid FCS → frame_err=3'b010, frame_len=20; 1600-byte frame with valid FCS → frame_err=3'b100, frame_len=1600.
- New in_sof after 30 bytes of a frame → out_abort pulse; old frame reports frame_done, frame_ok=0, frame_err=3'b011; the following good 64-byte frame passes with out_sof on its first byte.
- Assert rst for 1 cycle mid-frame (byte 10) → all outputs 0 next cycle, no frame_done, counters 0; bytes without in_sof afterwards are ignored.

Source files
------------

// File: rtl/eth_rx_frame_checker.sv
// Ethernet receive frame checker: on-the-fly CRC-32, length limits, FCS stripping
// and per-frame status with good/bad frame counters.
`timescale 1ns/1ps
module eth_rx_frame_checker #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_abort,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [2:0]       frame_err,
    output logic [10:0]      frame_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int unsigned LEN_W    = 11;
    localparam int unsigned DL_DEPTH = 4;
    localparam int unsigned HOLD_W   = 3;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic {
        IDLE,
        RX
    } state_t;

    state_t                       state, state_nxt;
    logic [31:0]                  crc, crc_nxt;
    logic [LEN_W-1:0]             len, len_nxt;
    logic [DL_DEPTH-1:0][7:0]     dl, dl_nxt;
    logic [HOLD_W-1:0]            held, held_nxt;
    logic                         emitted, emitted_nxt;

    logic [7:0]                   out_data_nxt;
    logic                         out_valid_nxt, out_sof_nxt, out_eof_nxt, out_abort_nxt;
    logic                         frame_done_nxt, frame_ok_nxt;
    logic [2:0]                   frame_err_nxt;
    logic [LEN_W-1:0]             frame_len_nxt;
    logic [CNT_W-1:0]             good_cnt_nxt, bad_cnt_nxt;

    logic                         fin_c;
    logic [LEN_W-1:0]             fin_len_c;
    logic                         fin_crc_bad_c;
    logic [LEN_W-1:0]             len_inc_c;
    logic [31:0]                  crc_fold_c;

    // One byte of reflected CRC-32, LSB first
    function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output preparation
    always_comb begin
        state_nxt      = state;
        crc_nxt        = crc;
        len_nxt        = len;
        dl_nxt         = dl;
        held_nxt       = held;
        emitted_nxt    = emitted;
        out_data_nxt   = 8'h00;
        out_valid_nxt  = 1'b0;
        out_sof_nxt    = 1'b0;
        out_eof_nxt    = 1'b0;
        out_abort_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        frame_ok_nxt   = frame_ok;
        frame_err_nxt  = frame_err;
        frame_len_nxt  = frame_len;
        good_cnt_nxt   = good_cnt;
        bad_cnt_nxt    = bad_cnt;
        fin_c          = 1'b0;
        fin_len_c      = '0;
        fin_crc_bad_c  = 1'b0;

        len_inc_c  = (len == '1) ? len : len + LEN_W'(1);
        crc_fold_c = crc_fold(crc, in_data);

        unique case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    crc_nxt     = crc_fold(CRC_INIT, in_data);
                    len_nxt     = LEN_W'(1);
                    dl_nxt      = {dl[DL_DEPTH-2:0], in_data};
                    held_nxt    = HOLD_W'(1);
                    emitted_nxt = 1'b0;
                    if (in_eof) begin
                        fin_c         = 1'b1;
                        fin_len_c     = LEN_W'(1);
                        fin_crc_bad_c = (crc_nxt != CRC_RESIDUE);
                    end else begin
                        state_nxt = RX;
                    end
                end
            end
            RX: begin
                if (in_valid && in_sof && !in_eof) begin
                    // Restart: close the old frame as bad and begin the new one on this byte
                    out_abort_nxt = emitted;
                    fin_c         = 1'b1;
                    fin_len_c     = len;
                    fin_crc_bad_c = 1'b1;
                    crc_nxt       = crc_fold(CRC_INIT, in_data);
                    len_nxt       = LEN_W'(1);
                    dl_nxt        = {dl[DL_DEPTH-2:0], in_data};
                    held_nxt      = HOLD_W'(1);
                    emitted_nxt   = 1'b0;
                end else if (in_valid) begin
                    crc_nxt = crc_fold_c;
                    len_nxt = len_inc_c;
                    dl_nxt  = {dl[DL_DEPTH-2:0], in_data};
                    if (held == HOLD_W'(DL_DEPTH)) begin
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = dl[DL_DEPTH-1];
                        out_sof_nxt   = !emitted;
                        out_eof_nxt   = in_eof;
                        emitted_nxt   = 1'b1;
                    end else begin
                        held_nxt = held + HOLD_W'(1);
                    end
                    if (in_eof) begin
                        fin_c         = 1'b1;
                        fin_len_c     = len_inc_c;
                        fin_crc_bad_c = (crc_fold_c != CRC_RESIDUE);
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame status and counters, common to every way a frame can end
        if (fin_c) begin
            frame_done_nxt = 1'b1;
            frame_len_nxt  = fin_len_c;
            frame_err_nxt  = {fin_len_c > LEN_W'(MAX_LEN), fin_len_c < LEN_W'(MIN_LEN), fin_crc_bad_c};
            frame_ok_nxt   = (frame_err_nxt == 3'b000);
            if (frame_ok_nxt) begin
                good_cnt_nxt = good_cnt + CNT_W'(1);
            end else begin
                bad_cnt_nxt = bad_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            len        <= '0;
            dl         <= '0;
            held       <= '0;
            emitted    <= 1'b0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_abort  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 3'b000;
            frame_len  <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            crc        <= crc_nxt;
            len        <= len_nxt;
            dl         <= dl_nxt;
            held       <= held_nxt;
            emitted    <= emitted_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            out_sof    <= out_sof_nxt;
            out_eof    <= out_eof_nxt;
            out_abort  <= out_abort_nxt;
            frame_done <= frame_done_nxt;
            frame_ok   <= frame_ok_nxt;
            frame_err  <= frame_err_nxt;
            frame_len  <= frame_len_nxt;
            good_cnt   <= good_cnt_nxt;
            bad_cnt    <= bad_cnt_nxt;
        end
    end

endmodule
